// File: rtl/prt_riscv_cpu_reg_ctl_pkg.sv
// Shared types for the register-file write-port controller.
// The optional read bypass is controlled by PRT_RISCV_CPU_REG_CTL_BYPASS_EN.
package prt_riscv_cpu_reg_ctl_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        REQ_EXE = 1'b0,
        REQ_LD  = 1'b1
    } req_e;

endpackage

// File: rtl/prt_riscv_cpu_reg_ctl_arb.sv
// Two-way round-robin arbiter between execute (bit 0) and load (bit 1) writeback.
// The pointer remembers the last winner and moves only when a grant is issued.
module prt_riscv_cpu_reg_ctl_arb
    import prt_riscv_cpu_reg_ctl_pkg::*;
(
    input  logic       CLK_IN,
    input  logic       RST_IN,
    input  logic       EN_IN,
    input  logic [1:0] VLD_IN,
    output logic [1:0] GNT_OUT
);

    req_e last_q;
    req_e last_d;

    // Grant selection and pointer next state; a grant always implies a transfer.
    always_comb begin
        GNT_OUT = 2'b00;
        last_d  = last_q;
        if (EN_IN) begin
            case (VLD_IN)
                2'b01:   GNT_OUT = 2'b01;
                2'b10:   GNT_OUT = 2'b10;
                2'b11:   GNT_OUT = (last_q == REQ_LD) ? 2'b01 : 2'b10;
                default: GNT_OUT = 2'b00;
            endcase
        end else begin
            GNT_OUT = 2'b00;
        end
        if (GNT_OUT[0]) begin
            last_d = REQ_EXE;
        end else if (GNT_OUT[1]) begin
            last_d = REQ_LD;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset makes execute win the first conflict.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            last_q <= REQ_LD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/prt_riscv_cpu_reg_ctl.sv
// Register-file write-port controller: zero sweep after reset, round-robin
// writeback arbitration, x0 drop, and read bypass when PRT_RISCV_CPU_REG_CTL_BYPASS_EN is defined.
module prt_riscv_cpu_reg_ctl
    import prt_riscv_cpu_reg_ctl_pkg::*;
#(
    parameter int P_REGS = 16,
    parameter int P_IDX  = 4
) (
    input  logic              CLK_IN,
    input  logic              RST_IN,
    input  logic [P_IDX-1:0]  EXE_IDX_IN,
    input  logic [DATA_W-1:0] EXE_DAT_IN,
    input  logic              EXE_VLD_IN,
    output logic              EXE_RDY_OUT,
    input  logic [P_IDX-1:0]  LD_IDX_IN,
    input  logic [DATA_W-1:0] LD_DAT_IN,
    input  logic              LD_VLD_IN,
    output logic              LD_RDY_OUT,
    output logic [P_IDX-1:0]  REG_IDX_OUT,
    output logic [DATA_W-1:0] REG_DAT_OUT,
    output logic              REG_WR_OUT,
    input  logic [P_IDX-1:0]  RS1_IDX_IN,
    input  logic [DATA_W-1:0] RS1_DAT_IN,
    output logic [DATA_W-1:0] RS1_DAT_OUT,
    input  logic [P_IDX-1:0]  RS2_IDX_IN,
    input  logic [DATA_W-1:0] RS2_DAT_IN,
    output logic [DATA_W-1:0] RS2_DAT_OUT,
    output logic              BUSY_OUT
);

    localparam logic [P_IDX-1:0] LAST_IDX = P_IDX'(P_REGS - 1);
    localparam logic [P_IDX-1:0] IDX_ZERO = {P_IDX{1'b0}};

    state_e            state_q, state_d;
    logic [P_IDX-1:0]  cnt_q, cnt_d;
    logic [P_IDX-1:0]  reg_idx_q, reg_idx_d;
    logic [DATA_W-1:0] reg_dat_q, reg_dat_d;
    logic              reg_wr_q, reg_wr_d;
    logic [1:0]        gnt_s;

    prt_riscv_cpu_reg_ctl_arb u_arb (
        .CLK_IN  (CLK_IN),
        .RST_IN  (RST_IN),
        .EN_IN   (state_q == RUN),
        .VLD_IN  ({LD_VLD_IN, EXE_VLD_IN}),
        .GNT_OUT (gnt_s)
    );

    // Init sweep / write-stage next state; idx and dat hold when nothing transfers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reg_idx_d = reg_idx_q;
        reg_dat_d = reg_dat_q;
        reg_wr_d  = 1'b0;
        case (state_q)
            INIT: begin
                reg_idx_d = cnt_q;
                reg_dat_d = {DATA_W{1'b0}};
                reg_wr_d  = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = RUN;
                    cnt_d   = IDX_ZERO;
                end else begin
                    state_d = INIT;
                    cnt_d   = cnt_q + P_IDX'(1);
                end
            end
            RUN: begin
                if (gnt_s[0]) begin
                    reg_idx_d = EXE_IDX_IN;
                    reg_dat_d = EXE_DAT_IN;
                    reg_wr_d  = (EXE_IDX_IN != IDX_ZERO);
                end else if (gnt_s[1]) begin
                    reg_idx_d = LD_IDX_IN;
                    reg_dat_d = LD_DAT_IN;
                    reg_wr_d  = (LD_IDX_IN != IDX_ZERO);
                end else begin
                    reg_wr_d = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = IDX_ZERO;
            end
        endcase
    end

    // State, sweep counter and write-port registers.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state_q   <= INIT;
            cnt_q     <= IDX_ZERO;
            reg_idx_q <= IDX_ZERO;
            reg_dat_q <= {DATA_W{1'b0}};
            reg_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reg_idx_q <= reg_idx_d;
            reg_dat_q <= reg_dat_d;
            reg_wr_q  <= reg_wr_d;
        end
    end

`ifdef PRT_RISCV_CPU_REG_CTL_BYPASS_EN
    function automatic logic [DATA_W-1:0] rd_sel(input logic [P_IDX-1:0] idx,
                                                 input logic [DATA_W-1:0] raw);
        if (idx == IDX_ZERO) begin
            return {DATA_W{1'b0}};
        end else if (reg_wr_q && (reg_idx_q == idx)) begin
            return reg_dat_q;
        end else begin
            return raw;
        end
    endfunction
`else
    function automatic logic [DATA_W-1:0] rd_sel(input logic [P_IDX-1:0] idx,
                                                 input logic [DATA_W-1:0] raw);
        return (idx == IDX_ZERO) ? {DATA_W{1'b0}} : raw;
    endfunction
`endif

    assign RS1_DAT_OUT = rd_sel(RS1_IDX_IN, RS1_DAT_IN);
    assign RS2_DAT_OUT = rd_sel(RS2_IDX_IN, RS2_DAT_IN);
    assign EXE_RDY_OUT = gnt_s[0];
    assign LD_RDY_OUT  = gnt_s[1];
    assign REG_IDX_OUT = reg_idx_q;
    assign REG_DAT_OUT = reg_dat_q;
    assign REG_WR_OUT  = reg_wr_q;
    assign BUSY_OUT    = (state_q == INIT);

endmodule
